// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS / AER event path (sensor geometry,
// interface clock, AER word format and the transmitter FSM encoding).
package dvs_ravens_pkg;

   localparam int unsigned CLK_PERIOD_NS   = 10;
   localparam int unsigned DVS_WIDTH_PXLS  = 346;
   localparam int unsigned DVS_HEIGHT_PXLS = 260;
   localparam int unsigned DVS_X_ADDR_BITS = $clog2(DVS_WIDTH_PXLS);
   localparam int unsigned DVS_Y_ADDR_BITS = $clog2(DVS_HEIGHT_PXLS);

   // 84 ns spacing caps the event rate at ~12 Mev/s
   localparam int unsigned DVS_MIN_EVENT_NS     = 84;
   localparam int unsigned DVS_MIN_EVENT_CYCLES =
      (DVS_MIN_EVENT_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;

   localparam int unsigned AER_DATA_BITS = 10;

   typedef enum logic [2:0] {
      AER_TX_IDLE,
      AER_TX_Y_SETUP,
      AER_TX_Y_REQ,
      AER_TX_Y_REL,
      AER_TX_X_SETUP,
      AER_TX_X_REQ,
      AER_TX_X_REL,
      AER_TX_GAP
   } aer_tx_state_t;

   function automatic logic [AER_DATA_BITS-1:0] aer_y_word(input logic pol, input logic [8:0] y);
      return {pol, y};
   endfunction

   function automatic logic [AER_DATA_BITS-1:0] aer_x_word(input logic pol, input logic [8:0] x);
      return {x, pol};
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/dvs_aer_transmitter.sv
// AER 4-phase sender: each pixel event becomes an optional row (Y) word and a
// column (X) word; the row word is skipped while the cached row is still fresh.
module dvs_aer_transmitter
   import dvs_ravens_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES       = 1,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned ROW_TIMEOUT_CYCLES = 100,
   parameter int unsigned MIN_EVENT_CYCLES   = DVS_MIN_EVENT_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ev_valid,
   output logic                       ev_ready,
   input  logic [DVS_X_ADDR_BITS-1:0] ev_x,
   input  logic [DVS_Y_ADDR_BITS-1:0] ev_y,
   input  logic                       ev_polarity,
   output logic [AER_DATA_BITS-1:0]   aer,
   output logic                       xsel,
   output logic                       req,
   input  logic                       ack,
   output logic                       busy,
   output logic [15:0]                events_sent
);

   localparam int unsigned IDLE_W  = $clog2(ROW_TIMEOUT_CYCLES + 1);
   localparam int unsigned GAP_W   = $clog2(MIN_EVENT_CYCLES + 1);
   localparam int unsigned SETUP_W = $clog2(SETUP_CYCLES + 1);
   localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(ROW_TIMEOUT_CYCLES);
   localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(MIN_EVENT_CYCLES - 1);
   localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES);

   aer_tx_state_t              state, state_next;
   logic                       ack_s;
   logic                       accept, y_needed, in_setup, setup_done;
   logic [DVS_X_ADDR_BITS-1:0] ev_x_q;
   logic [DVS_Y_ADDR_BITS-1:0] ev_y_q, last_y;
   logic                       pol_q, last_y_valid;
   logic [IDLE_W-1:0]          idle_cnt;
   logic [GAP_W-1:0]           gap_cnt;
   logic [SETUP_W-1:0]         setup_cnt;
   logic [AER_DATA_BITS-1:0]   word_y, word_x;

   sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ack),
      .q     (ack_s)
   );

   assign accept     = (state == AER_TX_IDLE) && ev_valid && ev_ready;
   assign y_needed   = !last_y_valid || (ev_y != last_y) || (idle_cnt >= IDLE_MAX);
   assign in_setup   = (state == AER_TX_Y_SETUP) || (state == AER_TX_X_SETUP);
   assign setup_done = (setup_cnt == SETUP_LAST);
   assign word_y     = aer_y_word(pol_q, 9'(ev_y_q));
   assign word_x     = aer_x_word(pol_q, 9'(ev_x_q));

   always_comb begin
      state_next = state;
      unique case (state)
         AER_TX_IDLE:    if (accept)     state_next = y_needed ? AER_TX_Y_SETUP : AER_TX_X_SETUP;
         AER_TX_Y_SETUP: if (setup_done) state_next = AER_TX_Y_REQ;
         AER_TX_Y_REQ:   if (ack_s)      state_next = AER_TX_Y_REL;
         AER_TX_Y_REL:   if (!ack_s)     state_next = AER_TX_X_SETUP;
         AER_TX_X_SETUP: if (setup_done) state_next = AER_TX_X_REQ;
         AER_TX_X_REQ:   if (ack_s)      state_next = AER_TX_X_REL;
         AER_TX_X_REL:   if (!ack_s)     state_next = AER_TX_GAP;
         AER_TX_GAP:     if (gap_cnt == '0) state_next = AER_TX_IDLE;
         default:        state_next = AER_TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= AER_TX_IDLE;
      else        state <= state_next;
   end

   // Handshake outputs are registered from the next state so they change on
   // the same edge as the transition that implies them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_ready     <= 1'b0;
         busy         <= 1'b0;
         req          <= 1'b0;
         aer          <= '0;
         xsel         <= 1'b0;
         events_sent  <= '0;
         ev_x_q       <= '0;
         ev_y_q       <= '0;
         pol_q        <= 1'b0;
         last_y       <= '0;
         last_y_valid <= 1'b0;
         idle_cnt     <= '0;
         gap_cnt      <= '0;
         setup_cnt    <= '0;
      end else begin
         ev_ready <= (state_next == AER_TX_IDLE);
         busy     <= (state_next != AER_TX_IDLE);
         req      <= (state_next == AER_TX_Y_REQ) || (state_next == AER_TX_X_REQ);

         if (accept) begin
            ev_x_q   <= ev_x;
            ev_y_q   <= ev_y;
            pol_q    <= ev_polarity;
            idle_cnt <= '0;
            gap_cnt  <= GAP_LOAD;
         end else begin
            if ((state == AER_TX_IDLE) && (idle_cnt != IDLE_MAX)) idle_cnt <= idle_cnt + 1'b1;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
         end

         if (state == AER_TX_Y_SETUP) begin
            aer  <= word_y;
            xsel <= 1'b0;
         end else if (state == AER_TX_X_SETUP) begin
            aer  <= word_x;
            xsel <= 1'b1;
         end

         setup_cnt <= (in_setup && !setup_done) ? setup_cnt + 1'b1 : '0;

         if ((state == AER_TX_Y_REL) && !ack_s) begin
            last_y       <= ev_y_q;
            last_y_valid <= 1'b1;
         end
         if ((state == AER_TX_X_REL) && !ack_s) events_sent <= events_sent + 1'b1;
      end
   end

endmodule
